// File: rtl/fifo_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_pkg
//   Shared types and constants for the FIFO-draining UART transmitter.
//   state_t   : transmitter FSM states (PARITY is used only when the parity
//               feature is built in with FIFO_UART_TX_PARITY_EN)
//   UART_BITS : data bits per frame
//   START_BIT : line level during the start bit
//   STOP_BIT  : line level during the stop bit and while idle
// -----------------------------------------------------------------------------
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int   UART_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/fifo_uart_baud_gen.sv
// -----------------------------------------------------------------------------
// fifo_uart_baud_gen
//   Bit-time counter for the UART transmitter. Counts 0..CLK_DIV-1 and wraps,
//   so one bit period is exactly CLK_DIV clocks.
//   Parameters: CLK_DIV - clk cycles per UART bit (>= 2)
//   Ports:
//     clk      in  clock
//     rst_n    in  asynchronous active-low reset
//     clear    in  pulse on the cycle before a state entry; reloads the count
//                  to 0 so the new state starts a full bit period
//     bit_done out high on the last cycle of a bit period (count == CLK_DIV-1)
// -----------------------------------------------------------------------------
module fifo_uart_baud_gen #(
    parameter int CLK_DIV = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign bit_done = (r_cnt == LAST_CNT);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Pops words from a first-word-fall-through FIFO read port and sends each
//   word as DATA_WIDTH/8 UART frames, least-significant byte first, LSB first
//   within a byte. Frames are 8N1, or 8 data + parity + 1 stop when the
//   FIFO_UART_TX_PARITY_EN macro is defined (PARITY_ODD selects odd parity).
//   Parameters: DATA_WIDTH (multiple of 8, 8..64), CLK_DIV (clk per bit, >= 2),
//               PARITY_ODD (1 = odd, 0 = even; parity build only)
//   Ports:
//     clk        in   clock, all logic on posedge
//     rst_n      in   asynchronous active-low reset
//     fifo_data  in   FIFO head word, valid while fifo_vld = 1
//     fifo_vld   in   FIFO head word valid
//     fifo_rd    out  pop strobe (combinational, only ever high in IDLE)
//     tx_en      in   allows a new word to start; never aborts one in flight
//     tx         out  registered UART line, idles at 1
//     busy       out  registered, high while any frame of a word is on the line
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 868,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_vld,
    output logic                  fifo_rd,
    input  logic                  tx_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int             NB        = DATA_WIDTH / 8;
    localparam int             BCW       = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(UART_BITS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_sreg;
    logic [2:0]            r_bit_cnt;
    logic [BCW-1:0]        r_byte_cnt;
    logic                  r_tx;
    logic                  r_busy;
    logic                  w_tx_next;
    logic                  w_pop;
    logic                  w_bit_done;
    logic                  w_baud_clear;
    logic                  w_last_bit;
    logic                  w_last_byte;

    assign w_pop       = (r_state == IDLE) && fifo_vld && tx_en;
    assign w_last_bit  = (r_bit_cnt == LAST_BIT);
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);
    // Reload the bit timer on every state change; consecutive DATA bits rely
    // on the timer's own wrap instead.
    assign w_baud_clear = (w_state_next != r_state);

    assign fifo_rd = w_pop;
    assign tx      = r_tx;
    assign busy    = r_busy;

    fifo_uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_baud_clear),
        .bit_done (w_bit_done)
    );

`ifdef FIFO_UART_TX_PARITY_EN
    // Running XOR of the bits already sent; the bit currently on the line is
    // folded in combinationally so the value is complete at the DATA exit.
    logic r_parity;
    logic w_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (r_state == START) begin
            r_parity <= 1'b0;
        end else if (r_state == DATA && w_bit_done) begin
            r_parity <= r_parity ^ r_sreg[0];
        end
    end

    assign w_parity = r_parity ^ r_sreg[0] ^ (PARITY_ODD != 0);
`else
    // Parity is not built in; PARITY_ODD has no effect.
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

    // Next state, plus the line level for the first cycle of that state so
    // the registered tx is already correct when the state is entered.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statements can infer a latch.
        w_state_next = r_state;
        w_tx_next    = STOP_BIT;

        case (r_state)
            IDLE:   if (w_pop)                    w_state_next = START;
            START:  if (w_bit_done)               w_state_next = DATA;
`ifdef FIFO_UART_TX_PARITY_EN
            DATA:   if (w_bit_done && w_last_bit) w_state_next = PARITY;
            PARITY: if (w_bit_done)               w_state_next = STOP;
`else
            DATA:   if (w_bit_done && w_last_bit) w_state_next = STOP;
`endif
            STOP:   if (w_bit_done)               w_state_next = w_last_byte ? IDLE : START;
            default:                              w_state_next = IDLE;
        endcase

        case (w_state_next)
            START: w_tx_next = START_BIT;
            // Mid-byte bit boundary: the register shifts on this edge, so the
            // next bit is the one currently at position 1.
            DATA:  w_tx_next = (r_state == DATA && w_bit_done) ? r_sreg[1] : r_sreg[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: w_tx_next = w_parity;
`endif
            default: w_tx_next = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tx    <= STOP_BIT;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

    // NOTE: the shift register is reset along with the counters so a word
    // aborted by reset leaves no stale data behind; it is a single register,
    // not a memory, so the reset costs nothing meaningful.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg     <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
        end else if (w_pop) begin
            r_sreg     <= fifo_data;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
        end else if (r_state == DATA && w_bit_done) begin
            // Eight shifts per byte leave the next byte's LSB at position 0.
            r_sreg    <= r_sreg >> 1;
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end else if (r_state == STOP && w_bit_done && !w_last_byte) begin
            r_byte_cnt <= r_byte_cnt + BCW'(1);
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int DW         = 32;
    localparam int CLK_DIV    = 4;
    localparam int PARITY_ODD = 0;
    localparam int NB         = DW / 8;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int F    = 44;   // 11 bit-times x 4 clk
    localparam int WORD = 176;  // 4 frames
`else
    localparam int F    = 40;   // 10 bit-times x 4 clk
    localparam int WORD = 160;  // 4 frames
`endif

    logic          clk;
    logic          rst_n = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_vld = 1'b0;
    logic          tx_en = 1'b0;
    logic          fifo_rd, tx, busy;

    logic [7:0]    fifo_data8 = '0;
    logic          fifo_vld8 = 1'b0;
    logic          tx_en8 = 1'b0;
    logic          fifo_rd8, tx8, busy8;

    int            n_checks = 0;
    int            n_errors = 0;
    int            pop_cnt  = 0;
    int            rd8_cnt  = 0;
    logic          vld_en   = 1'b0;
    logic [DW-1:0] src_q[$];
    logic          exp_q[$];
    logic          cap_tx[0:1023];
    logic          cap_busy[0:1023];
    logic          m_tx, m_busy, m_rd;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .PARITY_ODD(PARITY_ODD)) u_dut (
        .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_vld(fifo_vld),
        .fifo_rd(fifo_rd), .tx_en(tx_en), .tx(tx), .busy(busy)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(CLK_DIV), .PARITY_ODD(PARITY_ODD)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data8), .fifo_vld(fifo_vld8),
        .fifo_rd(fifo_rd8), .tx_en(tx_en8), .tx(tx8), .busy(busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the expected line level for every clk of one popped word.
    task automatic push_frame(input logic [DW-1:0] w);
        logic [7:0] b;
        for (int k = 0; k < NB; k++) begin
            b = w[8*k +: 8];
            repeat (CLK_DIV) exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (CLK_DIV) exp_q.push_back(b[i]);
`ifdef FIFO_UART_TX_PARITY_EN
            repeat (CLK_DIV) exp_q.push_back((^b) ^ (PARITY_ODD != 0));
`endif
            repeat (CLK_DIV) exp_q.push_back(1'b1);
        end
    endtask

    // Model + FIFO source: compare on every negedge, feed the head word at posedge+2.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                check("rst_tx", tx, 1'b1);
                check("rst_busy", busy, 1'b0);
                check("rst_rd", fifo_rd, 1'b0);
            end else begin
                m_busy = (exp_q.size() != 0);
                m_tx   = m_busy ? exp_q[0] : 1'b1;
                m_rd   = !m_busy && fifo_vld && tx_en;
                check("model_tx", tx, m_tx);
                check("model_busy", busy, m_busy);
                check("model_rd", fifo_rd, m_rd);
                if (m_busy) exp_q.delete(0);
                if (fifo_rd && fifo_vld) begin
                    pop_cnt++;
                    push_frame(fifo_data);
                    if (src_q.size() > 0) src_q.delete(0);
                end
            end
            @(posedge clk);
            #2;
            fifo_vld  = vld_en && (src_q.size() > 0);
            fifo_data = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    task automatic wait_pop(input int p0, input string name);
        int k;
        k = 0;
        while (pop_cnt == p0 && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, (pop_cnt != p0), 1'b1);
    endtask

    task automatic capture(input int n, input bit use8);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            cap_tx[i]   = use8 ? tx8 : tx;
            cap_busy[i] = use8 ? busy8 : busy;
            if (fifo_rd8) rd8_cnt++;
        end
    endtask

    function automatic logic [7:0] decode(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = cap_tx[base + CLK_DIV*(1+i) + CLK_DIV/2];
        return b;
    endfunction

    function automatic int busy_count(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) if (cap_busy[i]) c++;
        return c;
    endfunction

    logic [7:0]    lit_bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [DW-1:0] w0, w1, w5;
    int            p0, n_push, k8;

    initial begin
        // Reset, no stimulus
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_rd", fifo_rd, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Word queued but tx_en low for 100 clks: no pop
        p0 = pop_cnt;
        src_q.push_back(32'h44332211);
        vld_en = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("tx_en0_no_pop", pop_cnt - p0, 0);
        check("tx_en0_line_idle", tx, 1'b1);

        // Single word 0x44332211
        tx_en = 1'b1;
        wait_pop(p0, "w0_pop");
        capture(WORD + 4, 1'b0);
        for (int b = 0; b < NB; b++)
            check($sformatf("w0_byte%0d", b), decode(b * F), lit_bytes[b]);
        check("w0_first_bit_latency", cap_tx[0], 1'b0);
        check("w0_stop_bit", cap_tx[F-1], 1'b1);
        check("w0_busy_len", busy_count(WORD + 4), WORD);
        check("w0_busy_last", cap_busy[WORD-1], 1'b1);
        check("w0_busy_fall", cap_busy[WORD], 1'b0);
        check("w0_one_pop", pop_cnt - p0, 1);

        // Two words back-to-back
        p0 = pop_cnt;
        w0 = $urandom;
        w1 = $urandom;
        @(posedge clk); #1;
        src_q.push_back(w0);
        src_q.push_back(w1);
        wait_pop(p0, "b2b_pop0");
        capture(2*WORD + 4, 1'b0);
        check("b2b_pops", pop_cnt - p0, 2);
        check("b2b_gap_busy", cap_busy[WORD], 1'b0);
        check("b2b_gap_tx", cap_tx[WORD], 1'b1);
        check("b2b_start_tx", cap_tx[WORD+1], 1'b0);
        check("b2b_start_busy", cap_busy[WORD+1], 1'b1);
        check("b2b_busy_len", busy_count(2*WORD + 4), 2*WORD);
        for (int b = 0; b < NB; b++) begin
            check($sformatf("b2b_w0_byte%0d", b), decode(b * F), w0[8*b +: 8]);
            check($sformatf("b2b_w1_byte%0d", b), decode(WORD + 1 + b * F), w1[8*b +: 8]);
        end

        // tx_en dropped 10 clks after the pop
        p0 = pop_cnt;
        @(posedge clk); #1;
        src_q.push_back($urandom);
        src_q.push_back($urandom);
        wait_pop(p0, "txen_pop0");
        repeat (10) @(posedge clk);
        #1 tx_en = 1'b0;
        repeat (WORD + 40) @(negedge clk);
        #1;
        check("txen_word_done_one_pop", pop_cnt - p0, 1);
        check("txen_idle_busy", busy, 1'b0);
        check("txen_idle_rd", fifo_rd, 1'b0);
        @(posedge clk); #1 tx_en = 1'b1;
        wait_pop(p0 + 1, "txen_resume_pop");
        repeat (WORD + 4) @(negedge clk);
        #1;
        check("txen_resume_done", busy, 1'b0);
        check("txen_total_pops", pop_cnt - p0, 2);

        // Reset during byte 1 DATA
        p0 = pop_cnt;
        @(posedge clk); #1;
        src_q.push_back($urandom);
        wait_pop(p0, "rst_mid_pop");
        repeat (F + CLK_DIV + 7) @(posedge clk);
        #1;
        check("rst_mid_busy_before", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        p0 = pop_cnt;
        w5 = $urandom;
        src_q.push_back(w5);
        wait_pop(p0, "rst_after_pop");
        capture(F + 2, 1'b0);
        check("rst_after_start0", cap_tx[0], 1'b0);
        check("rst_after_start3", cap_tx[CLK_DIV-1], 1'b0);
        check("rst_after_byte0", decode(0), w5[7:0]);
        repeat (WORD) @(negedge clk);

        // Randomized traffic with tx_en / fifo_vld toggling
        n_push = 0;
        for (int c = 0; c < 8000 && (n_push < 20 || src_q.size() > 0 || busy); c++) begin
            @(posedge clk); #1;
            if (n_push < 20 && $urandom_range(0, 15) == 0) begin
                src_q.push_back($urandom);
                n_push++;
            end
            if ($urandom_range(0, 31) == 0) tx_en = ~tx_en;
            if ($urandom_range(0, 31) == 0) vld_en = ~vld_en;
            if (n_push == 20) begin
                tx_en  = 1'b1;
                vld_en = 1'b1;
            end
        end
        check("rand_drained", src_q.size(), 0);
        check("rand_idle", busy, 1'b0);

`ifdef FIFO_UART_TX_PARITY_EN
        // Parity literal: byte 0x07 has three ones -> even parity bit 1
        p0 = pop_cnt;
        src_q.push_back(32'h0000_0007);
        wait_pop(p0, "par_pop");
        capture(WORD + 2, 1'b0);
        check("par_byte0", decode(0), 8'h07);
        check("par_bit_0x07", cap_tx[CLK_DIV*9 + CLK_DIV/2], 1'b1);
        check("par_bit_0x00", cap_tx[F + CLK_DIV*9 + CLK_DIV/2], 1'b0);
        repeat (4) @(negedge clk);
`endif

        // DATA_WIDTH=8 instance: one byte per pop
        fifo_data8 = 8'hA5;
        tx_en8     = 1'b1;
        @(posedge clk); #1 fifo_vld8 = 1'b1;
        k8 = 0;
        while (!fifo_rd8 && k8 < 100) begin
            @(negedge clk);
            k8++;
        end
        check("dw8_pop", fifo_rd8, 1'b1);
        @(posedge clk); #1 fifo_vld8 = 1'b0;
        rd8_cnt = 0;
        capture(F + 4, 1'b1);
        check("dw8_no_extra_pop", rd8_cnt, 0);
        check("dw8_byte", decode(0), 8'hA5);
        check("dw8_busy_len", busy_count(F + 4), F);
        check("dw8_busy_fall", cap_busy[F], 1'b0);
        check("dw8_idle_tx", cap_tx[F], 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
